round_arbiter: RTL and testbench

// - Shares one round-half-to-even datapath between N requester ports.
// - Each port offers a fixed-point word (DW bits, FW fraction bits) on a valid/ready handshake.
// - A round-robin arbiter grants one port per cycle and feeds its word through the rounding core.
// - The integer result is held in a registered output slot, tagged with the source port id.
// - Sits between multiple fixed-point producers and a single integer consumer.
//

---
 rtl/round_pkg.sv | 13 +
 rtl/round_rne.sv | 30 +++
 rtl/round_arbiter.sv | 104 ++++++++++
 tb/tb_round_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Shared helpers for the round-half-to-even arbiter: derived widths used by
// the top level and the rounding core.
package round_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int int_width(input int dw, input int fw);
    return dw - fw;
  endfunction

endpackage

// File: rtl/round_rne.sv
// Combinational round-half-to-even of an unsigned fixed-point word to its
// integer field; ovf flags the increment wrapping the integer field.
module round_rne
  import round_pkg::*;
#(
  parameter int DW = 16,
  parameter int FW = 8,
  localparam int IW = int_width(DW, FW)
) (
  input  logic [DW-1:0] a,
  output logic [IW-1:0] res,
  output logic          ovf
);

  logic [IW-1:0] w_int;
  logic          w_half;
  logic          w_tail;
  logic          w_up;
  logic [IW:0]   w_sum;

  assign w_int  = a[DW-1:FW];
  assign w_half = a[FW-1];
  assign w_tail = |a[FW-2:0];
  // Exact ties round toward the even integer.
  assign w_up   = w_half & (w_tail | w_int[0]);

  assign w_sum      = {1'b0, w_int} + {{IW{1'b0}}, w_up};
  assign {ovf, res} = w_sum;

endmodule

// File: rtl/round_arbiter.sv
// N-port round-robin front end sharing one rounding core; the rounded result
// is held in a single registered output slot tagged with its source port.
module round_arbiter
  import round_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int FW = 8,
  localparam int IW = int_width(DW, FW),
  localparam int ID = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]  req_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_data,
  output logic [ID-1:0] out_id,
  output logic          out_ovf
);

  logic [ID-1:0] r_ptr;
  logic          r_valid;
  logic [IW-1:0] r_data;
  logic [ID-1:0] r_id;
  logic          r_ovf;

  logic          w_accept;
  logic          w_found;
  logic [ID-1:0] w_grant;
  logic [ID-1:0] w_next_ptr;
  logic [DW-1:0] w_word;
  logic [IW-1:0] w_res;
  logic          w_ovf;

  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= N) ? s - N : s;
  endfunction

  // Held low during reset so no port sees a ready while the slot is cleared.
  assign w_accept = (!r_valid || out_ready) && !rst;

  // Each port's ready depends only on ports ahead of it in the search order,
  // never on its own valid, so producers may wait on ready before raising valid.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    req_ready = '0;
    w_found   = 1'b0;
    w_grant   = '0;
    w_word    = '0;
    for (int k = 0; k < N; k++) begin
      req_ready[wrap_idx(int'(r_ptr), k)] = w_accept && !w_found;
      if (!w_found && req_valid[wrap_idx(int'(r_ptr), k)]) begin
        w_found = 1'b1;
        w_grant = ID'(wrap_idx(int'(r_ptr), k));
        w_word  = req_data[wrap_idx(int'(r_ptr), k)*DW +: DW];
      end
    end
  end

  assign w_next_ptr = (int'(w_grant) + 1 >= N) ? '0 : w_grant + ID'(1);

  round_rne #(
    .DW (DW),
    .FW (FW)
  ) u_rne (
    .a   (w_word),
    .res (w_res),
    .ovf (w_ovf)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_data  <= w_res;
        r_id    <= w_grant;
        r_ovf   <= w_ovf;
        r_ptr   <= w_next_ptr;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_round_arbiter.sv
// Directed bench for round_arbiter (N=4, DW=16, FW=8): rounding vectors,
// wrap, pointer skip, fairness, backpressure and asynchronous reset.
module tb_round_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int IW = 8;
  localparam int ID = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_data;
  logic [ID-1:0]   out_id;
  logic            out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  round_arbiter #(
    .N  (N),
    .DW (DW),
    .FW (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int port, input logic [DW-1:0] w);
    req_data[port*DW +: DW] = w;
  endtask

  // One word on one port with the slot free; result checked a cycle later.
  task automatic send_one(input string tag, input int port, input logic [DW-1:0] w,
                          input logic [IW-1:0] exp_d, input logic exp_ovf);
    set_word(port, w);
    req_valid = N'(1) << port;
    out_ready = 1'b1;
    #1;
    check({tag, ".grant"}, 32'(req_ready & req_valid), 32'(N'(1) << port));
    tick();
    req_valid = '0;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data),  32'(exp_d));
    check({tag, ".id"},    32'(out_id),    32'(port));
    check({tag, ".ovf"},   32'(out_ovf),   32'(exp_ovf));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '0;
    out_ready = 1'b0;
    #3;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data",  32'(out_data),  32'd0);
    check("rst.id",    32'(out_id),    32'd0);
    check("rst.ovf",   32'(out_ovf),   32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst       = 1'b0;
    req_valid = '0;

    send_one("rne_0180", 0, 16'h0180, 8'h02, 1'b0);
    send_one("rne_0280", 0, 16'h0280, 8'h02, 1'b0);
    send_one("rne_0281", 0, 16'h0281, 8'h03, 1'b0);
    send_one("rne_037f", 0, 16'h037F, 8'h03, 1'b0);
    send_one("rne_0080", 0, 16'h0080, 8'h00, 1'b0);
    send_one("rne_00c0", 0, 16'h00C0, 8'h01, 1'b0);
    send_one("wrap",     2, 16'hFF80, 8'h00, 1'b1);

    tick();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Pointer sits at 3 after the port-2 grant.
    set_word(3, 16'h0400);
    set_word(0, 16'h0500);
    req_valid = 4'b1000;
    #1;
    check("skip.grant3", 32'(req_ready & req_valid), 32'b1000);
    tick();
    check("skip.id3", 32'(out_id), 32'd3);
    check("skip.data3", 32'(out_data), 32'h04);
    req_valid = 4'b1001;
    #1;
    check("skip.grant0", 32'(req_ready & req_valid), 32'b0001);
    tick();
    check("skip.id0", 32'(out_id), 32'd0);
    check("skip.data0", 32'(out_data), 32'h05);
    #1;
    check("skip.grant3b", 32'(req_ready & req_valid), 32'b1000);
    tick();
    check("skip.id3b", 32'(out_id), 32'd3);
    req_valid = '0;

    // Pointer back at 0: all ports valid, port i carries integer i+1.
    for (int i = 0; i < N; i++) set_word(i, DW'((i + 1) << FW));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("fair%0d.grant", k), 32'(req_ready & req_valid), 32'(1 << (k % N)));
      tick();
      check($sformatf("fair%0d.id", k), 32'(out_id), 32'(k % N));
      check($sformatf("fair%0d.data", k), 32'(out_data), 32'(k % N + 1));
    end

    // Slot holds id 3 / data 4, pointer at 0.
    out_ready = 1'b0;
    req_valid = 4'b1010;
    set_word(1, 16'h0A80);
    set_word(3, 16'h0B80);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d.ready", c), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d.valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d.id", c), 32'(out_id), 32'd3);
      check($sformatf("bp%0d.data", c), 32'(out_data), 32'h04);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("rel.grant1", 32'(req_ready & req_valid), 32'b0010);
    tick();
    check("rel.id1", 32'(out_id), 32'd1);
    check("rel.data1", 32'(out_data), 32'h0A);
    req_valid = 4'b1000;
    #1;
    check("rel.grant3", 32'(req_ready & req_valid), 32'b1000);
    tick();
    check("rel.id3", 32'(out_id), 32'd3);
    check("rel.data3", 32'(out_data), 32'h0C);
    req_valid = '0;
    tick();
    check("rel.drain", 32'(out_valid), 32'd0);

    // Leave pointer at 3 with a held result, then reset asynchronously.
    set_word(2, 16'h0500);
    req_valid = 4'b0100;
    tick();
    check("mid.valid", 32'(out_valid), 32'd1);
    set_word(2, 16'h0700);
    set_word(3, 16'h0900);
    req_valid = 4'b1100;
    rst = 1'b1;
    #1;
    check("mid.rst.valid", 32'(out_valid), 32'd0);
    check("mid.rst.data",  32'(out_data),  32'd0);
    check("mid.rst.id",    32'(out_id),    32'd0);
    check("mid.rst.ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post.grant", 32'(req_ready & req_valid), 32'b0100);
    tick();
    check("post.valid", 32'(out_valid), 32'd1);
    check("post.id", 32'(out_id), 32'd2);
    check("post.data", 32'(out_data), 32'h07);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
